// File: rtl/pio_mailbox_bridge_pkg.sv
// Shared types and default constants for the PIO mailbox bridge.
package pio_mailbox_bridge_pkg;

    localparam int unsigned DEF_NUM_CH = 16;
    localparam int unsigned DEF_RSP_CH = 4;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DEPTH  = 2;
    localparam int unsigned SEQ_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_BLOCKED = 2'd2
    } req_state_t;

endpackage

// File: rtl/mailbox_frame_fifo.sv
// First-word-fall-through frame FIFO; head entry is visible whenever the level is non-zero.
module mailbox_frame_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_valid,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_valid = (r_level != '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];

    // Full/empty come from the registered level, so a same-cycle pop never frees a slot for a push.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && o_valid;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/pio_mailbox_bridge.sv
// Software/hardware mailbox: 4-phase command handshake into a frame FIFO, plus a latched response word.
module pio_mailbox_bridge
    import pio_mailbox_bridge_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned RSP_CH = DEF_RSP_CH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset,
    input  logic [NUM_CH*DATA_W-1:0]   sw_cmd_data,
    input  logic                       sw_req,
    output logic                       sw_ack,
    output logic [NUM_CH*DATA_W-1:0]   frame_data,
    output logic [SEQ_W-1:0]           frame_seq,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    input  logic [RSP_CH*DATA_W-1:0]   rsp_data,
    input  logic                       rsp_valid,
    output logic                       rsp_ready,
    output logic [RSP_CH*DATA_W-1:0]   sw_rsp_data,
    output logic                       sw_rsp_flag,
    input  logic                       sw_rsp_clr,
    output logic [SEQ_W-1:0]           sw_frame_count,
    output logic [$clog2(DEPTH):0]     sw_fifo_level
);

    localparam int unsigned CMD_W   = NUM_CH * DATA_W;
    localparam int unsigned RSP_W   = RSP_CH * DATA_W;
    localparam int unsigned FRAME_W = CMD_W + SEQ_W;

    req_state_t          r_state;
    req_state_t          w_state_nxt;
    logic                r_ack;
    logic                r_req_d;
    logic                r_clr_d;
    logic [SEQ_W-1:0]    r_frame_count;
    logic                r_rsp_flag;
    logic [RSP_W-1:0]    r_rsp_data;
    logic                w_req_rise;
    logic                w_clr_rise;
    logic                w_push;
    logic                w_full;
    logic                w_valid;
    logic                w_rsp_take;
    logic [FRAME_W-1:0]  w_head;

    assign w_req_rise = sw_req && !r_req_d;
    assign w_clr_rise = sw_rsp_clr && !r_clr_d;
    assign w_rsp_take = rsp_valid && !r_rsp_flag;

    // Request handshake: capture on entry to HOLD, park in BLOCKED while the FIFO is full.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_rise) begin
                    if (!w_full) begin
                        w_state_nxt = ST_HOLD;
                        w_push      = 1'b1;
                    end else begin
                        w_state_nxt = ST_BLOCKED;
                    end
                end
            end
            ST_HOLD: begin
                if (!sw_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BLOCKED: begin
                if (!sw_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_full) begin
                    w_state_nxt = ST_HOLD;
                    w_push      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state       <= ST_IDLE;
            r_ack         <= 1'b0;
            r_req_d       <= 1'b0;
            r_clr_d       <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= (w_state_nxt == ST_HOLD);
            r_req_d <= sw_req;
            r_clr_d <= sw_rsp_clr;
            if (w_push) begin
                r_frame_count <= r_frame_count + SEQ_W'(1);
            end
        end
    end

    // Response latch; a clear edge can only act while the flag is set, so it never races an accept.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_rsp_flag <= 1'b0;
            r_rsp_data <= '0;
        end else if (w_rsp_take) begin
            r_rsp_flag <= 1'b1;
            r_rsp_data <= rsp_data;
        end else if (w_clr_rise) begin
            r_rsp_flag <= 1'b0;
        end
    end

    mailbox_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .i_push      (w_push),
        .i_wdata     ({r_frame_count, sw_cmd_data}),
        .i_pop       (frame_ready),
        .o_rdata     (w_head),
        .o_valid     (w_valid),
        .o_full      (w_full),
        .o_level     (sw_fifo_level)
    );

    assign sw_ack         = r_ack;
    assign frame_valid    = w_valid;
    assign frame_seq      = w_head[FRAME_W-1 -: SEQ_W];
    assign frame_data     = w_head[CMD_W-1:0];
    assign rsp_ready      = !r_rsp_flag;
    assign sw_rsp_flag    = r_rsp_flag;
    assign sw_rsp_data    = r_rsp_data;
    assign sw_frame_count = r_frame_count;

endmodule

// File: tb/tb_pio_mailbox_bridge.sv
// Randomised bench for pio_mailbox_bridge against a queue-based mailbox model.
module tb_pio_mailbox_bridge;

    localparam int unsigned CMD_W = 16 * 32;
    localparam int unsigned RSP_W = 4 * 32;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic [CMD_W-1:0]  sw_cmd_data;
    logic              sw_req;
    logic              sw_ack;
    logic [CMD_W-1:0]  frame_data;
    logic [7:0]        frame_seq;
    logic              frame_valid;
    logic              frame_ready;
    logic [RSP_W-1:0]  rsp_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RSP_W-1:0]  sw_rsp_data;
    logic              sw_rsp_flag;
    logic              sw_rsp_clr;
    logic [7:0]        sw_frame_count;
    logic [1:0]        sw_fifo_level;

    typedef struct {
        logic [CMD_W-1:0] data;
        logic [7:0]       seq;
    } frm_t;

    frm_t       q[$];
    logic [7:0] model_count;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         rand_ready = 1'b0;

    pio_mailbox_bridge dut (
        .clk_clk        (clk_clk),
        .reset_reset    (reset_reset),
        .sw_cmd_data    (sw_cmd_data),
        .sw_req         (sw_req),
        .sw_ack         (sw_ack),
        .frame_data     (frame_data),
        .frame_seq      (frame_seq),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .rsp_data       (rsp_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .sw_rsp_data    (sw_rsp_data),
        .sw_rsp_flag    (sw_rsp_flag),
        .sw_rsp_clr     (sw_rsp_clr),
        .sw_frame_count (sw_frame_count),
        .sw_fifo_level  (sw_fifo_level)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [CMD_W-1:0] got, input logic [CMD_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
        if (rand_ready) frame_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [CMD_W-1:0] rnd_frame();
        logic [CMD_W-1:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [RSP_W-1:0] rnd_rsp();
        logic [RSP_W-1:0] v;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Consumer side of the model: FIFO occupancy and head frame follow the queue.
    always @(negedge clk_clk) begin
        if (reset_reset === 1'b0) begin
            check("level", CMD_W'(sw_fifo_level), CMD_W'(q.size()));
            check("valid", CMD_W'(frame_valid), CMD_W'(q.size() != 0));
            if (frame_valid === 1'b1 && q.size() != 0) begin
                check("head_seq", CMD_W'(frame_seq), CMD_W'(q[0].seq));
                check("head_data", frame_data, q[0].data);
                if (frame_ready === 1'b1) void'(q.pop_front());
            end
        end
    end

    task automatic model_capture(input logic [CMD_W-1:0] d);
        q.push_back('{data: d, seq: model_count});
        model_count++;
        check("frame_count", CMD_W'(sw_frame_count), CMD_W'(model_count));
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        q.delete();
        model_count = 8'd0;
        tick();
        check("rst_ack", CMD_W'(sw_ack), '0);
        check("rst_valid", CMD_W'(frame_valid), '0);
        check("rst_level", CMD_W'(sw_fifo_level), '0);
        check("rst_count", CMD_W'(sw_frame_count), '0);
        check("rst_seq", CMD_W'(frame_seq), '0);
        check("rst_data", frame_data, '0);
        check("rst_flag", CMD_W'(sw_rsp_flag), '0);
        check("rst_rsp_data", CMD_W'(sw_rsp_data), '0);
        check("rst_rsp_ready", CMD_W'(rsp_ready), CMD_W'(1));
        reset_reset = 1'b0;
    endtask

    task automatic send_frame(input logic [CMD_W-1:0] d);
        bit got = 1'b0;
        sw_cmd_data = d;
        sw_req = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (sw_ack === 1'b1) got = 1'b1;
        end
        check("ack_rise", CMD_W'(got), CMD_W'(1));
        if (got) model_capture(d);
        sw_req = 1'b0;
        tick();
        check("ack_fall", CMD_W'(sw_ack), '0);
    endtask

    initial begin
        logic [CMD_W-1:0] d;
        logic [RSP_W-1:0] r;
        reset_reset = 1'b1;
        sw_cmd_data = '0;
        sw_req      = 1'b0;
        frame_ready = 1'b0;
        rsp_data    = '0;
        rsp_valid   = 1'b0;
        sw_rsp_clr  = 1'b0;
        model_count = 8'd0;
        do_reset();

        // Single frame with an always-ready consumer.
        frame_ready = 1'b1;
        d = '0;
        d[31:0] = 32'hDEADBEEF;
        sw_cmd_data = d;
        sw_req = 1'b1;
        tick();
        check("single_ack", CMD_W'(sw_ack), CMD_W'(1));
        check("single_valid", CMD_W'(frame_valid), CMD_W'(1));
        check("single_seq", CMD_W'(frame_seq), '0);
        check("single_data", frame_data, d);
        model_capture(d);
        sw_req = 1'b0;
        tick();
        check("single_popped", CMD_W'(frame_valid), '0);

        // Full FIFO: third request parks until one slot drains.
        do_reset();
        frame_ready = 1'b0;
        send_frame(rnd_frame());
        send_frame(rnd_frame());
        d = rnd_frame();
        sw_cmd_data = d;
        sw_req = 1'b1;
        repeat (3) tick();
        check("blk_ack", CMD_W'(sw_ack), '0);
        check("blk_level", CMD_W'(sw_fifo_level), CMD_W'(2));
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("blk_same_cycle", CMD_W'(sw_ack), '0);
        tick();
        check("blk_release_ack", CMD_W'(sw_ack), CMD_W'(1));
        check("blk_third_count", CMD_W'(sw_frame_count), CMD_W'(3));
        model_capture(d);
        sw_req = 1'b0;
        tick();

        // Abandon while blocked: no capture, count unchanged.
        sw_cmd_data = rnd_frame();
        sw_req = 1'b1;
        repeat (2) tick();
        check("abn_ack", CMD_W'(sw_ack), '0);
        sw_req = 1'b0;
        repeat (2) tick();
        check("abn_ack_idle", CMD_W'(sw_ack), '0);
        check("abn_count", CMD_W'(sw_frame_count), CMD_W'(3));
        frame_ready = 1'b1;
        repeat (3) tick();
        check("abn_drained", CMD_W'(sw_fifo_level), '0);
        send_frame(rnd_frame());

        // Response path: hold-off while flagged, clear wins over a waiting response.
        do_reset();
        rsp_data = RSP_W'(32'h1234);
        rsp_valid = 1'b1;
        tick();
        check("rsp_flag", CMD_W'(sw_rsp_flag), CMD_W'(1));
        check("rsp_ready_low", CMD_W'(rsp_ready), '0);
        check("rsp_data", CMD_W'(sw_rsp_data), CMD_W'(32'h1234));
        rsp_data = RSP_W'(32'h5678);
        repeat (2) tick();
        check("rsp_held_flag", CMD_W'(sw_rsp_flag), CMD_W'(1));
        check("rsp_held_data", CMD_W'(sw_rsp_data), CMD_W'(32'h1234));
        sw_rsp_clr = 1'b1;
        tick();
        check("clr_flag", CMD_W'(sw_rsp_flag), '0);
        check("clr_keep_data", CMD_W'(sw_rsp_data), CMD_W'(32'h1234));
        check("clr_ready", CMD_W'(rsp_ready), CMD_W'(1));
        tick();
        check("second_flag", CMD_W'(sw_rsp_flag), CMD_W'(1));
        check("second_data", CMD_W'(sw_rsp_data), CMD_W'(32'h5678));
        rsp_valid = 1'b0;
        sw_rsp_clr = 1'b0;
        tick();
        for (int k = 0; k < 20; k++) begin
            sw_rsp_clr = 1'b1;
            tick();
            check("rnd_clr_flag", CMD_W'(sw_rsp_flag), '0);
            sw_rsp_clr = 1'b0;
            r = rnd_rsp();
            rsp_data = r;
            rsp_valid = 1'b1;
            tick();
            rsp_valid = 1'b0;
            rsp_data = rnd_rsp();
            check("rnd_rsp_flag", CMD_W'(sw_rsp_flag), CMD_W'(1));
            check("rnd_rsp_data", CMD_W'(sw_rsp_data), CMD_W'(r));
            repeat ($urandom_range(0, 2)) tick();
            check("rnd_rsp_keep", CMD_W'(sw_rsp_data), CMD_W'(r));
        end

        // Sequence wrap over 256 frames.
        do_reset();
        frame_ready = 1'b1;
        for (int k = 0; k < 256; k++) send_frame(rnd_frame());
        check("wrap_count", CMD_W'(sw_frame_count), '0);

        // Random consumer back-pressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 150; k++) send_frame(rnd_frame());
        rand_ready = 1'b0;
        frame_ready = 1'b1;
        repeat (4) tick();
        check("rand_drained", CMD_W'(sw_fifo_level), '0);

        // Reset mid-HOLD with a pending response and a queued frame.
        rsp_data = rnd_rsp();
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        frame_ready = 1'b0;
        d = rnd_frame();
        sw_cmd_data = d;
        sw_req = 1'b1;
        tick();
        check("hold_ack", CMD_W'(sw_ack), CMD_W'(1));
        model_capture(d);
        do_reset();
        tick();
        check("recap_ack", CMD_W'(sw_ack), CMD_W'(1));
        check("recap_valid", CMD_W'(frame_valid), CMD_W'(1));
        check("recap_seq", CMD_W'(frame_seq), '0);
        model_capture(d);
        sw_req = 1'b0;
        frame_ready = 1'b1;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pio_mailbox_bridge.md
PIO_MAILBOX_BRIDGE -- requirements
Module: pio_mailbox_bridge

Interface
REQ-001 SHALL have parameter NUM_CH, default 16: number of SW->HW command words.
REQ-002 SHALL have parameter RSP_CH, default 4: number of HW->SW response words.
REQ-003 SHALL have parameter DATA_W, default 32: width of each word.
REQ-004 SHALL have parameter DEPTH, default 2, power of two >= 2: command frame FIFO depth.
REQ-005 SHALL have one clock and one reset: the clock is clk_clk; the reset is reset_reset, synchronous and active-high.
REQ-006 clk_clk  in  1  system clock; all logic rising-edge.
REQ-007 reset_reset  in  1  synchronous active-high reset.
REQ-008 sw_cmd_data  in  NUM_CH*DATA_W  SW-written command words; word i at bits [i*DATA_W +: DATA_W].
REQ-009 sw_req  in  1  SW request level, 4-phase handshake.
REQ-010 sw_ack  out  1  request acknowledge to SW.
REQ-011 frame_data  out  NUM_CH*DATA_W  head-of-FIFO command frame.
REQ-012 frame_seq  out  8  sequence number of the head frame.
REQ-013 frame_valid / frame_ready  out / in  1 / 1  consumer valid/ready pair.
REQ-014 rsp_data / rsp_valid / rsp_ready  in / in / out  RSP_CH*DATA_W / 1 / 1  HW response, valid/ready.
REQ-015 sw_rsp_data / sw_rsp_flag  out / out  RSP_CH*DATA_W / 1  latched response and "response pending" flag to SW.
REQ-016 sw_rsp_clr  in  1  SW response-clear strobe; rising edge acts.
REQ-017 sw_frame_count / sw_fifo_level  out / out  8 / clog2(DEPTH)+1  accepted-frame count and FIFO occupancy.

Function
REQ-018 Request FSM SHALL have states IDLE, HOLD and BLOCKED.
REQ-019 In IDLE, a sw_req 0->1 edge SHALL go to HOLD if the FIFO is not full, or to BLOCKED if it is full.
REQ-020 The edge is detected against a registered copy of sw_req.
REQ-021 Entering HOLD SHALL, on that same edge, push sw_cmd_data with seq = sw_frame_count, then increment sw_frame_count modulo 256.
REQ-022 sw_ack SHALL be 1 exactly while in HOLD, i.e. from the cycle after capture.
REQ-023 HOLD SHALL return to IDLE when sw_req = 0.
REQ-024 BLOCKED SHALL move to HOLD with capture when the FIFO is not full.
REQ-025 BLOCKED SHALL return to IDLE with no capture if sw_req drops first.
REQ-026 Full/not-full decisions SHALL use the registered level: a pop in the same cycle does not free a slot for that cycle's push.
REQ-027 When a push and a pop occur in the same cycle, both SHALL complete and the level SHALL be unchanged.
REQ-028 The FIFO SHALL be first-word-fall-through: frame_valid = (level != 0).
REQ-029 frame_data and frame_seq SHALL be stable while frame_valid && !frame_ready.
REQ-030 A frame SHALL be popped on frame_valid && frame_ready.
REQ-031 Capture to frame_valid latency SHALL be 1 cycle when the FIFO was empty.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH.
REQ-033 rsp_ready SHALL equal !sw_rsp_flag.
REQ-034 On rsp_valid && rsp_ready, sw_rsp_data SHALL latch rsp_data and sw_rsp_flag SHALL be 1 the next cycle.
REQ-035 A sw_rsp_clr 0->1 edge SHALL clear sw_rsp_flag; sw_rsp_data SHALL be retained.
REQ-036 Clear and rsp_valid in the same cycle while the flag is 1: the clear wins and the response is accepted no earlier than the next cycle.

Reset
REQ-037 On reset_reset, the FSM SHALL go to IDLE.
REQ-038 On reset_reset, sw_ack, frame_valid, sw_rsp_flag, sw_frame_count, sw_fifo_level and the pointers SHALL be 0.
REQ-039 On reset_reset, frame_seq, frame_data and sw_rsp_data SHALL be 0.
REQ-040 On reset_reset, rsp_ready SHALL be 1 from the first post-reset cycle.
REQ-041 On reset_reset, the edge-detect registers SHALL load 0.
REQ-042 After reset, a sw_req already high SHALL be seen as a rising edge.
REQ-043 Reset asserted mid-handshake SHALL discard all FIFO contents and any pending response.

Structure
REQ-044 A shared package SHALL hold the FSM state enum, the default parameter constants and the SEQ_W = 8 constant.
REQ-045 The frame FIFO SHALL be one sub-module, mailbox_frame_fifo, parameterised on width (NUM_CH*DATA_W + 8) and DEPTH.
REQ-046 The FSM and the response register SHALL live in the top module.

Verification
REQ-047 Single frame: word0 = 0xDEADBEEF, raise sw_req, frame_ready = 1 -> sw_ack high next cycle, frame_valid 1 cycle, frame_seq = 0, sw_frame_count = 1.
REQ-048 Full FIFO (DEPTH = 2): frame_ready = 0, three handshakes -> third parks in BLOCKED with sw_ack = 0 and sw_fifo_level = 2; one pop -> ack asserts and frame_seq of the third frame = 2.
REQ-049 Abandon: sw_req high then low while BLOCKED -> no capture, sw_frame_count unchanged.
REQ-050 Response: rsp_valid with 0x1234 -> sw_rsp_flag = 1 and rsp_ready = 0; a second response is held off; sw_rsp_clr edge -> flag 0 and the second response is latched the cycle after.
REQ-051 Wrap: 256 frames -> sw_frame_count returns to 0 and frame_seq sequence 255 -> 0 is contiguous.
REQ-052 Reset mid-HOLD with sw_req still high -> all outputs 0 (rsp_ready = 1), then recapture on the next cycle as a fresh edge.
